// File: rtl/dm_cache_ctrl_if.sv
// dm_cache_ctrl_if: bundles the CPU-side request/response signals and the
// backing-memory bus of the direct-mapped cache controller.
//   slave  : the cache controller's view (takes CPU requests and memory
//            responses, drives CPU responses and memory requests)
//   master : the surrounding system's view (CPU requester plus memory)
// CPU side : cpu_req, cpu_we, cpu_addr, cpu_wdata, flush -> controller
//            cpu_rdata, cpu_ready, cpu_hit, busy         <- controller
// Mem side : mem_req, mem_we, mem_addr, mem_wdata        <- controller
//            mem_rdata, mem_ack                          -> controller
interface dm_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_hit;
  logic              busy;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_hit, busy,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_hit, busy,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache
// controller, one word per line, between one CPU requester and a memory bus.
// Owns the tag/valid/data arrays and sequences lookup, refill and
// write-through with an IDLE/LOOKUP/MEMWAIT FSM. All outputs are registered.
// Ports:
//   clk, rst   : clock; synchronous active-high reset
//   bus        : dm_cache_ctrl_if.slave (CPU request/response + memory bus)
//   hit_count  : saturating count of completed hits   (CACHE_STATS_EN only)
//   miss_count : saturating count of completed misses (CACHE_STATS_EN only)
// Build option: define CACHE_STATS_EN to add the hit/miss statistics ports.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 6
) (
  input  logic clk,
  input  logic rst,
  dm_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
  localparam int unsigned LINES = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEMWAIT} state_t;

  state_t state, state_next;

  // storage; tags and data are not reset, valid qualifies them
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [LINES-1:0]  valid;

  // latched request
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_hit;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               lookup_hit;

  // registered outputs
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_ready_q;
  logic              cpu_hit_q;
  logic              busy_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // next values / control strobes from the output decoder
  logic [DATA_W-1:0] cpu_rdata_d;
  logic              cpu_ready_d;
  logic              cpu_hit_d;
  logic              mem_req_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              accept;
  logic              flush_all;
  logic              data_wr;
  logic              fill;
  logic              hit_save;

  assign req_index  = req_addr[INDEX_W+1:2];
  assign req_tag    = req_addr[ADDR_W-1:INDEX_W+2];
  assign lookup_hit = valid[req_index] && (tag_mem[req_index] == req_tag);

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_hit   = cpu_hit_q;
  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // state register plus registered outputs and control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid       <= '0;
      req_hit     <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_next;
      busy_q      <= (state_next != IDLE);
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (hit_save) req_hit <= lookup_hit;
      if (flush_all) valid <= '0;
      else if (fill) valid[req_index] <= 1'b1;
    end
  end

  // request latch and array writes; arrays are frozen while rst is high so
  // an aborted transaction leaves no trace
  always_ff @(posedge clk) begin
    if (accept) begin
      req_we    <= bus.cpu_we;
      req_addr  <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
      req_wdata <= bus.cpu_wdata;
    end
    if (!rst) begin
      if (data_wr) begin
        data_mem[req_index] <= req_wdata;
      end else if (fill) begin
        data_mem[req_index] <= bus.mem_rdata;
        tag_mem[req_index]  <= req_tag;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!bus.flush && bus.cpu_req) state_next = LOOKUP;
      LOOKUP:  state_next = (!req_we && lookup_hit) ? IDLE : MEMWAIT;
      MEMWAIT: if (bus.mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // output decoder: next values of the registered outputs and array strobes
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    accept      = 1'b0;
    flush_all   = 1'b0;
    data_wr     = 1'b0;
    fill        = 1'b0;
    hit_save    = 1'b0;
    unique case (state)
      IDLE: begin
        // flush wins; a coincident request is dropped
        if (bus.flush)        flush_all = 1'b1;
        else if (bus.cpu_req) accept    = 1'b1;
      end
      LOOKUP: begin
        if (!req_we && lookup_hit) begin
          cpu_ready_d = 1'b1;
          cpu_hit_d   = 1'b1;
          cpu_rdata_d = data_mem[req_index];
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = req_we;
          mem_addr_d = req_addr;
          if (req_we) begin
            mem_wdata_d = req_wdata;
            data_wr     = lookup_hit;
            hit_save    = 1'b1;
          end
        end
      end
      MEMWAIT: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          cpu_ready_d = 1'b1;
          if (req_we) begin
            cpu_hit_d = req_hit;
          end else begin
            fill        = 1'b1;
            cpu_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  // counted on the edge that raises cpu_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cpu_ready_d) begin
      if (cpu_hit_d) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: randomized self-checking bench for dm_cache_ctrl.
// A line-level reference model (valid/tag/data per index, computed from the
// address arithmetic) predicts hit/miss, read data, memory traffic and
// latency; directed scenarios cover flush, flush/request collision and reset
// during a refill. Define CACHE_STATS_EN to also check the statistics ports.
module tb_dm_cache_ctrl;

  localparam int unsigned LINES = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_cache_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dm_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .INDEX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  int unsigned m_hits   = 0;
  int unsigned m_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_stats();
`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
  endtask

  // Called at a negedge with the controller idle; returns at the negedge of
  // the cpu_ready cycle so a following call exercises back-to-back requests.
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned dly,
                         input logic [31:0] mdata);
    int unsigned idx;
    logic [31:0] tg;
    logic        exp_hit;
    logic        need_mem;
    logic [31:0] exp_rdata;
    int unsigned cycles;
    int unsigned mem_cycles;
    bit          got_ready;
    bit          saw_mem;
    idx        = (addr >> 2) % LINES;
    tg         = addr >> 8;
    exp_hit    = m_valid[idx] && (m_tag[idx] == tg);
    need_mem   = we || !exp_hit;
    exp_rdata  = exp_hit ? m_data[idx] : mdata;
    cycles     = 0;
    mem_cycles = 0;
    got_ready  = 0;
    saw_mem    = 0;

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;
    cycles = 1;
    check("busy_after_req", bus.busy, 1);
    check("ready_one_cycle", bus.cpu_ready, 0);
    check_stats();

    while (!got_ready && cycles < 64) begin
      if (bus.cpu_ready) begin
        got_ready = 1;
      end else begin
        if (bus.mem_req) begin
          saw_mem = 1;
          check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
          check("mem_we", bus.mem_we, we);
          if (we) check("mem_wdata", bus.mem_wdata, wdata);
          bus.mem_ack   = (mem_cycles == dly);
          bus.mem_rdata = (mem_cycles == dly) ? mdata : $urandom;
          mem_cycles++;
        end else begin
          // stray acks without a request must be ignored
          bus.mem_ack   = ($urandom_range(0, 3) == 0);
          bus.mem_rdata = $urandom;
        end
        @(negedge clk);
        cycles++;
      end
    end
    bus.mem_ack = 1'b0;

    check("ready_seen", got_ready, 1);
    if (got_ready) begin
      check("latency", cycles, need_mem ? 3 + dly : 2);
      check("used_mem", saw_mem, need_mem);
      check("cpu_hit", bus.cpu_hit, exp_hit);
      if (!we) check("cpu_rdata", bus.cpu_rdata, exp_rdata);
      check("mem_req_dropped", bus.mem_req, 0);
      check("busy_at_ready", bus.busy, 0);
      if (!we && !exp_hit) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        m_data[idx]  = mdata;
      end
      if (we && exp_hit) m_data[idx] = wdata;
      if (exp_hit) m_hits++;
      else m_misses++;
    end
  endtask

  // Called at a negedge with the controller idle.
  task automatic do_flush(input bit with_req, input logic [31:0] addr);
    bus.flush    = 1'b1;
    bus.cpu_req  = with_req;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.cpu_req = 1'b0;
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("flush_busy", bus.busy, 0);
      check("flush_ready", bus.cpu_ready, 0);
      check("flush_mem_req", bus.mem_req, 0);
      @(negedge clk);
    end
    check_stats();
  endtask

  task automatic reset_mid_refill(input logic [31:0] addr);
    int unsigned n;
    do_flush(0, 32'h0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = addr;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    n = 0;
    while (!bus.mem_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("mid_mem_req", bus.mem_req, 1);
    @(negedge clk);
    // ack lands on the reset edge: must be neither completed nor filled
    rst           = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = $urandom;
    @(negedge clk);
    rst         = 1'b0;
    bus.mem_ack = 1'b0;
    model_reset();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ready", bus.cpu_ready, 0);
    check_stats();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ready", bus.cpu_ready, 0);
      check("post_rst_busy", bus.busy, 0);
    end
    run_txn(0, addr, 32'h0, 1, 32'hA5A5_0001);
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.flush     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", bus.cpu_ready, 0);
    check("rst_cpu_hit", bus.cpu_hit, 0);
    check("rst_busy0", bus.busy, 0);
    check("rst_mem_req0", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check_stats();
    rst = 1'b0;
    @(negedge clk);

    // cold read then repeat read
    run_txn(0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
    run_txn(0, 32'h100, 32'h0, 0, 32'h0);
    @(negedge clk);
    check_stats();

    // conflict eviction on index 0
    run_txn(0, 32'h200, 32'h0, 1, 32'h2222_2222);
    run_txn(0, 32'h100, 32'h0, 0, 32'h1111_1111);

    // write hit, then write miss with no allocate
    run_txn(1, 32'h100, 32'h1234_5678, 2, 32'h0);
    run_txn(0, 32'h100, 32'h0, 0, 32'h0);
    run_txn(1, 32'h300, 32'hCAFE_F00D, 0, 32'h0);
    run_txn(0, 32'h300, 32'h0, 1, 32'h3333_3333);

    // flush, then a flush colliding with a request
    do_flush(0, 32'h0);
    run_txn(0, 32'h100, 32'h0, 0, 32'h4444_4444);
    do_flush(1, 32'h100);
    run_txn(0, 32'h100, 32'h0, 0, 32'h5555_5555);

    reset_mid_refill(32'h204);

    // random traffic over 4 indices x 4 tags to mix hits, misses and evictions
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        do_flush($urandom_range(0, 1) == 1, a);
      end else begin
        run_txn($urandom_range(0, 9) < 4, a, $urandom, $urandom_range(0, 4), $urandom);
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
    end

    @(negedge clk);
    check_stats();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller with one 32-bit word per line. It sits between a single CPU-side requester and the backing memory bus. It owns the tag, valid and data arrays, and sequences lookup, refill and write-through via a three-state FSM. It provides single-cycle whole-cache flush and optional hit/miss statistics.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- INDEX_W, 6, line index bits (2**INDEX_W lines)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  request strobe, sampled when busy=0
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  hit flag, valid while cpu_ready=1
- busy  out  1  state != IDLE
- flush  in  1  invalidate all lines, sampled when busy=0
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge
- hit_count  out  32  (CACHE_STATS_EN only)
- miss_count  out  32  (CACHE_STATS_EN only)

## Operation
- Address split:
  - index = addr[INDEX_W+1:2]
  - tag = addr[ADDR_W-1:INDEX_W+2]
- Valid bits are a flop vector, so they can be cleared in one cycle.
- FSM states are IDLE, LOOKUP, MEMWAIT.
- **IDLE**
  - flush=1: clear all valid bits and stay IDLE. flush has priority; a coincident cpu_req is dropped, not queued.
  - Otherwise, cpu_req=1: latch we, addr and wdata, then go to LOOKUP.
- **LOOKUP** (hit = valid[index] and stored tag == latched tag)
  - Read hit: cpu_rdata=data[index], cpu_ready=1, cpu_hit=1, go to IDLE.
  - Read miss: mem_req=1, mem_we=0, go to MEMWAIT.
  - Write hit: data[index]=wdata. Write miss: no array change.
  - Write (hit or miss): mem_req=1, mem_we=1, mem_wdata=wdata, remember the hit flag, go to MEMWAIT.
- **MEMWAIT**: hold mem_req, mem_we, mem_addr and mem_wdata stable until mem_ack.
  - Read on ack: data[index]=mem_rdata, tag[index]=tag, valid[index]=1; cpu_rdata=mem_rdata, cpu_ready=1, cpu_hit=0; drop mem_req; go to IDLE.
  - Write on ack: cpu_ready=1, cpu_hit=remembered flag, drop mem_req, go to IDLE.
- mem_ack while mem_req=0 is ignored.
- Requester rule: a cpu_req held high in any cycle with busy=0 counts as a new request. Requesters pulse cpu_req for exactly one cycle per transaction.

## Timing
- All outputs are registered.
- Reset:
  - state=IDLE; all valid bits=0.
  - cpu_ready, cpu_hit, busy, mem_req and mem_we = 0.
  - cpu_rdata, mem_addr and mem_wdata = 0; counters = 0.
- Read hit:
  - cpu_req sampled at edge E0.
  - cpu_ready is high in the cycle after E1, for exactly one cycle.
- Miss or write:
  - mem_req is high from E1.
  - With mem_ack sampled at edge Ek, cpu_ready is high for the cycle after Ek and mem_req is low from Ek.
  - Minimum latency is 3 cycles, when ack arrives in the first mem_req cycle.
- Back-to-back: the cpu_ready cycle is an IDLE cycle, so a cpu_req in that cycle is accepted.
- Reset mid-transaction: state goes to IDLE and mem_req is low after the reset edge. cpu_ready is never asserted for the aborted transaction. No array update occurs, except the valid clear done by reset.
- Stored tags and data are not reset; valid=0 makes them unused.

## Configuration
- **CACHE_STATS_EN defined**:
  - hit_count and miss_count ports exist.
  - On each cpu_ready pulse, increment hit_count if cpu_hit=1, else miss_count.
  - Both counters saturate at 0xFFFFFFFF.
  - Both are cleared by rst only; flush does not clear them.
- **CACHE_STATS_EN undefined**: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Cold read, then repeat read:
  - After rst, read 0x100; ack 3 cycles after mem_req with 0xDEADBEEF → mem_addr=0x100, mem_we=0; cpu_ready with rdata=0xDEADBEEF, hit=0.
  - Re-read 0x100 → cpu_ready 2 cycles after req with hit=1, no mem_req.
- Conflict eviction: read 0x100, read 0x200 (same index 0, different tag), read 0x100 → all three miss with three memory reads. The final read returns the fresh mem_rdata.
- Write hit, then write miss:
  - Write 0x100=0x12345678 on a valid line → mem write with wdata 0x12345678; cpu_ready hit=1 after ack; a later read of 0x100 hits with 0x12345678.
  - Write to 0x300 (uncached) → hit=0; a later read of 0x300 misses (no allocate).
- Flush and collision:
  - Load 0x100, pulse flush, read 0x100 → miss.
  - flush and cpu_req in the same IDLE cycle → request dropped, busy stays 0.
- Reset mid-refill: rst while in MEMWAIT → mem_req=0 and busy=0 the next cycle; no cpu_ready; a later read of that address misses.
- Statistics (CACHE_STATS_EN): the first scenario gives hit_count=1, miss_count=1; a subsequent rst gives both = 0.
